// File: rtl/writeback_trace_checker_pkg.sv
// Shared types for the writeback trace checker.
// FSM state encoding and fixed counter widths.
package writeback_trace_checker_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CYCLE_WIDTH = 32;

endpackage

// File: rtl/writeback_trace_checker_trace_ram.sv
// Expected-trace store: one synchronous write port, one asynchronous read port.
// Contents survive reset so a rerun needs no reload.
module writeback_trace_checker_trace_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 37,
    parameter int IW    = 8
) (
    input  logic             clock,
    input  logic             write_enable,
    input  logic [IW-1:0]    write_index,
    input  logic [WIDTH-1:0] write_data,
    input  logic [IW-1:0]    read_index,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_index] <= write_data;
        end
    end

    assign read_data = mem[read_index];

endmodule

// File: rtl/writeback_trace_checker.sv
// Sequences CPU reset, then checks every register-file writeback against
// an expected {address,data} trace; reports pass/fail/timeout.
module writeback_trace_checker
    import writeback_trace_checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TRACE_DEPTH    = 256,
    parameter int RESET_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STOP_ON_FIRST  = 1,
    parameter int IGNORE_ZERO    = 1,
    localparam int IW = $clog2(TRACE_DEPTH),
    localparam int EW = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_enable,
    input  logic [IW-1:0]          load_index,
    input  logic [EW-1:0]          load_data,
    input  logic [IW:0]            expected_count,
    input  logic                   wb_enable,
    input  logic [ADDR_WIDTH-1:0]  wb_address,
    input  logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [IW:0]            mismatch_count,
    output logic [IW-1:0]          first_error,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);

    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TRACE_DEPTH);
    localparam logic [CW-1:0] SAT_C   = '1;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            hold_cnt;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          index_q;
    logic [EW-1:0]          rd_entry;
    logic                   running;
    logic                   wb_take;
    logic                   at_end;
    logic                   cmp_fail;
    logic                   overrun;
    logic                   last_cycle;
    logic                   stop;
    logic                   timeout_hit;
    logic                   pass_next;

    writeback_trace_checker_trace_ram #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (EW),
        .IW    (IW)
    ) u_ram (
        .clock        (clock),
        .write_enable (load_enable && (state == HOLD)),
        .write_index  (load_index),
        .write_data   (load_data),
        .read_index   (index_q[IW-1:0]),
        .read_data    (rd_entry)
    );

    always_comb begin
        running    = (state == RUN);
        wb_take    = wb_enable &&
                     !((IGNORE_ZERO != 0) && (wb_address == '0));
        at_end     = (index_q == count_q);
        cmp_fail   = running && wb_take && !at_end &&
                     ({wb_address, wb_data} != rd_entry);
        overrun    = running && wb_take && at_end;
        last_cycle = (cycle_count == 32'(TIMEOUT_CYCLES - 1));
        stop       = cmp_fail && (STOP_ON_FIRST != 0);
    end

    always_comb begin
        state_next  = state;
        cpu_reset   = 1'b1;
        timeout_hit = 1'b0;
        pass_next   = 1'b0;
        unique case (state)
            HOLD: begin
                if (hold_cnt == 32'(RESET_CYCLES - 1)) state_next = RUN;
            end
            RUN: begin
                cpu_reset = 1'b0;
                if (at_end || stop || last_cycle) state_next = DONE;
                // end-of-trace and mismatches outrank the timeout
                timeout_hit = last_cycle && !at_end && !cmp_fail;
                pass_next   = at_end && !overrun && (mismatch_count == '0);
            end
            DONE: state_next = DONE;
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= HOLD;
            hold_cnt       <= '0;
            count_q        <= '0;
            index_q        <= '0;
            cycle_count    <= '0;
            mismatch_count <= '0;
            first_error    <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state <= state_next;
            if (state == HOLD) begin
                hold_cnt <= hold_cnt + 32'd1;
                if (state_next == RUN) begin
                    count_q <= (expected_count > DEPTH_C) ?
                               DEPTH_C : expected_count;
                end
            end
            if (running) begin
                if (state_next == RUN) cycle_count <= cycle_count + 1'b1;
                if (wb_take && !at_end) index_q <= index_q + 1'b1;
                if (cmp_fail) begin
                    if (mismatch_count != SAT_C) begin
                        mismatch_count <= mismatch_count + 1'b1;
                    end
                    if (mismatch_count == '0) first_error <= index_q[IW-1:0];
                end
                if (state_next == DONE) begin
                    done    <= 1'b1;
                    pass    <= pass_next;
                    timeout <= timeout_hit;
                end
            end
        end
    end

endmodule
